// File: rtl/steer_pkg.sv
// Shared definitions for the steering-angle controller: FSM state encoding,
// I2C master instruction codes and the per-state I2C command table.
package steer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_DEV_WR,
        ST_REG_ADDR,
        ST_RESTART,
        ST_DEV_RD,
        ST_RD_HI,
        ST_RD_LO,
        ST_STOP,
        ST_EVAL,
        ST_PWM_WAIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [1:0] I2C_START = 2'd0;
    localparam logic [1:0] I2C_STOP  = 2'd1;
    localparam logic [1:0] I2C_READ  = 2'd2;
    localparam logic [1:0] I2C_WRITE = 2'd3;

    typedef struct packed {
        logic [1:0] instr;
        logic [7:0] wr_data;
        logic       nack;
    } i2c_cmd_t;

    // States that own an outstanding I2C instruction.
    function automatic logic is_i2c_state(input state_t st);
        return (st inside {ST_START, ST_DEV_WR, ST_REG_ADDR, ST_RESTART,
                           ST_DEV_RD, ST_RD_HI, ST_RD_LO, ST_STOP});
    endfunction

    // Instruction issued when the FSM enters an I2C state.
    function automatic i2c_cmd_t entry_cmd(input state_t     st,
                                           input logic [6:0] dev_addr,
                                           input logic [7:0] reg_addr);
        i2c_cmd_t c;
        c = '{instr: I2C_START, wr_data: 8'h00, nack: 1'b0};
        case (st)
            ST_DEV_WR:   begin c.instr = I2C_WRITE; c.wr_data = {dev_addr, 1'b0}; end
            ST_REG_ADDR: begin c.instr = I2C_WRITE; c.wr_data = reg_addr;         end
            ST_DEV_RD:   begin c.instr = I2C_WRITE; c.wr_data = {dev_addr, 1'b1}; end
            ST_RD_HI:    c.instr = I2C_READ;
            ST_RD_LO:    begin c.instr = I2C_READ; c.nack = 1'b1; end
            ST_STOP:     c.instr = I2C_STOP;
            default:     c.instr = I2C_START;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/steer_angle_ctrl_err_calc.sv
// Combinational shortest-path error between target and measured angle,
// giving drive direction, on-target flag and the clamped proportional ratio.
module steer_err_calc
    import steer_pkg::*;
#(
    parameter int ANGLE_W   = 12,
    parameter int PWM_W     = 8,
    parameter int TOLERANCE = 4,
    parameter int KP_SHIFT  = 2,
    parameter int MIN_RATIO = 20
) (
    input  logic [ANGLE_W-1:0] target,
    input  logic [ANGLE_W-1:0] current,
    output logic               on_target,
    output logic               dir,
    output logic [PWM_W-1:0]   ratio
);

    localparam logic [31:0] RATIO_MAX = 32'((64'd1 << PWM_W) - 64'd1);
    localparam logic [31:0] RATIO_MIN = 32'(MIN_RATIO);
    localparam logic [31:0] TOL       = 32'(TOLERANCE);

    logic [ANGLE_W-1:0] err;
    logic [ANGLE_W-1:0] mag;
    logic [31:0]        scaled;

    // Modular difference read as signed; the half-turn value keeps dir=0.
    always_comb begin
        err       = target - current;
        dir       = ~err[ANGLE_W-1];
        mag       = err[ANGLE_W-1] ? (ANGLE_W'(0) - err) : err;
        on_target = (32'(mag) <= TOL);
        scaled    = 32'(mag) >> KP_SHIFT;
        if (scaled < RATIO_MIN) scaled = RATIO_MIN;
        if (scaled > RATIO_MAX) scaled = RATIO_MAX;
        ratio     = scaled[PWM_W-1:0];
    end

endmodule

// File: rtl/steer_angle_ctrl.sv
// Closed-loop steering-angle controller: reads a 12-bit magnetic encoder over
// a byte-level I2C master, computes the wrap-around error to the target and
// drives PWM ratio/direction until within tolerance.
// Optional I2C watchdog enabled by defining STEER_TIMEOUT_EN.
module steer_angle_ctrl
    import steer_pkg::*;
#(
    parameter int         ANGLE_W     = 12,
    parameter int         PWM_W       = 8,
    parameter logic [6:0] DEV_ADDR    = 7'h36,
    parameter logic [7:0] ANGLE_REG   = 8'h0C,
    parameter int         TOLERANCE   = 4,
    parameter int         KP_SHIFT    = 2,
    parameter int         MIN_RATIO   = 20,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [ANGLE_W-1:0] target_angle,
    input  logic               angle_update,
    output logic               angle_done,
    output logic               busy,
    output logic               error,
    output logic               i2c_req,
    output logic [1:0]         i2c_instruction,
    output logic [7:0]         i2c_wr_data,
    output logic               i2c_send_nack,
    input  logic [7:0]         i2c_rd_data,
    input  logic               i2c_done,
    input  logic               pwm_done,
    output logic               pwm_enable,
    output logic [PWM_W-1:0]   pwm_ratio,
    output logic               pwm_direction,
    output logic               pwm_update
);

    state_t             state_q, state_d;
    logic [ANGLE_W-1:0] target_q, target_d;
    logic [7:0]         rd_hi_q, rd_hi_d;
    logic [ANGLE_W-1:0] cur_q, cur_d;
    logic               angle_done_q, angle_done_d;
    logic               busy_q, busy_d;
    logic               i2c_req_q, i2c_req_d;
    i2c_cmd_t           i2c_cmd_q, i2c_cmd_d;
    logic               pwm_enable_q, pwm_enable_d;
    logic [PWM_W-1:0]   pwm_ratio_q, pwm_ratio_d;
    logic               pwm_dir_q, pwm_dir_d;
    logic               pwm_update_q, pwm_update_d;
    logic               error_q, error_d;

    logic [15:0]        raw_angle;
    logic               on_target;
    logic               calc_dir;
    logic [PWM_W-1:0]   calc_ratio;

    assign raw_angle = {rd_hi_q, i2c_rd_data};

    if (ANGLE_W < 16) begin : g_mask
        logic unused_raw_hi;
        assign unused_raw_hi = ^raw_angle[15:ANGLE_W];
    end

    steer_err_calc #(
        .ANGLE_W   (ANGLE_W),
        .PWM_W     (PWM_W),
        .TOLERANCE (TOLERANCE),
        .KP_SHIFT  (KP_SHIFT),
        .MIN_RATIO (MIN_RATIO)
    ) u_err_calc (
        .target    (target_q),
        .current   (cur_q),
        .on_target (on_target),
        .dir       (calc_dir),
        .ratio     (calc_ratio)
    );

`ifdef STEER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

    // Next-state and registered-output computation for the read/evaluate loop.
    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d      = state_q;
        target_d     = angle_update ? target_angle : target_q;
        rd_hi_d      = rd_hi_q;
        cur_d        = cur_q;
        angle_done_d = 1'b0;
        busy_d       = busy_q;
        i2c_req_d    = 1'b0;
        i2c_cmd_d    = i2c_cmd_q;
        pwm_enable_d = pwm_enable_q;
        pwm_ratio_d  = pwm_ratio_q;
        pwm_dir_d    = pwm_dir_q;
        pwm_update_d = 1'b0;
        error_d      = error_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (angle_update) begin
                    state_d = ST_START;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START:    if (i2c_done) state_d = ST_DEV_WR;
            ST_DEV_WR:   if (i2c_done) state_d = ST_REG_ADDR;
            ST_REG_ADDR: if (i2c_done) state_d = ST_RESTART;
            ST_RESTART:  if (i2c_done) state_d = ST_DEV_RD;
            ST_DEV_RD:   if (i2c_done) state_d = ST_RD_HI;
            ST_RD_HI: begin
                if (i2c_done) begin
                    rd_hi_d = i2c_rd_data;
                    state_d = ST_RD_LO;
                end
            end
            ST_RD_LO: begin
                if (i2c_done) begin
                    cur_d   = raw_angle[ANGLE_W-1:0];
                    state_d = ST_STOP;
                end
            end
            ST_STOP:     if (i2c_done) state_d = ST_EVAL;
            ST_EVAL: begin
                pwm_update_d = 1'b1;
                if (on_target) begin
                    pwm_enable_d = 1'b0;
                    angle_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_DONE;
                end else begin
                    pwm_enable_d = 1'b1;
                    pwm_ratio_d  = calc_ratio;
                    pwm_dir_d    = calc_dir;
                    state_d      = ST_PWM_WAIT;
                end
            end
            ST_PWM_WAIT: if (pwm_done) state_d = ST_START;
            ST_ERROR: begin
                if (angle_update) begin
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_START;
                end
            end
            default:     state_d = ST_IDLE;
        endcase

`ifdef STEER_TIMEOUT_EN
        if (is_i2c_state(state_q) && !i2c_done &&
            (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1))) begin
            state_d      = ST_ERROR;
            error_d      = 1'b1;
            busy_d       = 1'b0;
            pwm_enable_d = 1'b0;
            pwm_update_d = 1'b1;
        end
`endif

        // Entering any I2C state launches its instruction exactly once.
        if (is_i2c_state(state_d) && (state_d != state_q)) begin
            i2c_req_d = 1'b1;
            i2c_cmd_d = entry_cmd(state_d, DEV_ADDR, ANGLE_REG);
        end

`ifdef STEER_TIMEOUT_EN
        if (i2c_req_d)                   wd_cnt_d = '0;
        else if (is_i2c_state(state_q))  wd_cnt_d = wd_cnt_q + 1'b1;
        else                             wd_cnt_d = wd_cnt_q;
`endif
    end

    // State and output registers; reset returns every output to zero at once.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            rd_hi_q      <= '0;
            cur_q        <= '0;
            angle_done_q <= 1'b0;
            busy_q       <= 1'b0;
            i2c_req_q    <= 1'b0;
            i2c_cmd_q    <= '0;
            pwm_enable_q <= 1'b0;
            pwm_ratio_q  <= '0;
            pwm_dir_q    <= 1'b0;
            pwm_update_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            rd_hi_q      <= rd_hi_d;
            cur_q        <= cur_d;
            angle_done_q <= angle_done_d;
            busy_q       <= busy_d;
            i2c_req_q    <= i2c_req_d;
            i2c_cmd_q    <= i2c_cmd_d;
            pwm_enable_q <= pwm_enable_d;
            pwm_ratio_q  <= pwm_ratio_d;
            pwm_dir_q    <= pwm_dir_d;
            pwm_update_q <= pwm_update_d;
            error_q      <= error_d;
        end
    end

`ifdef STEER_TIMEOUT_EN
    // Watchdog counter measuring cycles since the last I2C request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) wd_cnt_q <= '0;
        else          wd_cnt_q <= wd_cnt_d;
    end
    assign error = error_q;
`else
    logic unused_error;
    assign unused_error = error_q;
    assign error        = 1'b0;
`endif

    assign angle_done      = angle_done_q;
    assign busy            = busy_q;
    assign i2c_req         = i2c_req_q;
    assign i2c_instruction = i2c_cmd_q.instr;
    assign i2c_wr_data     = i2c_cmd_q.wr_data;
    assign i2c_send_nack   = i2c_cmd_q.nack;
    assign pwm_enable      = pwm_enable_q;
    assign pwm_ratio       = pwm_ratio_q;
    assign pwm_direction   = pwm_dir_q;
    assign pwm_update      = pwm_update_q;

endmodule

// File: tb/tb_steer_angle_ctrl.sv
// Scoreboard bench for steer_angle_ctrl: directed stimulus pushes expected
// I2C instructions and PWM updates; a monitor pops and compares them.
module tb_steer_angle_ctrl;
    import steer_pkg::*;

`ifdef STEER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 100;
`else
    localparam int TB_TIMEOUT = 65535;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [11:0] target_angle;
    logic        angle_update;
    logic        angle_done, busy, error;
    logic        i2c_req;
    logic [1:0]  i2c_instruction;
    logic [7:0]  i2c_wr_data;
    logic        i2c_send_nack;
    logic [7:0]  i2c_rd_data;
    logic        i2c_done;
    logic        pwm_done;
    logic        pwm_enable;
    logic [7:0]  pwm_ratio;
    logic        pwm_direction;
    logic        pwm_update;

    steer_angle_ctrl #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .target_angle    (target_angle),
        .angle_update    (angle_update),
        .angle_done      (angle_done),
        .busy            (busy),
        .error           (error),
        .i2c_req         (i2c_req),
        .i2c_instruction (i2c_instruction),
        .i2c_wr_data     (i2c_wr_data),
        .i2c_send_nack   (i2c_send_nack),
        .i2c_rd_data     (i2c_rd_data),
        .i2c_done        (i2c_done),
        .pwm_done        (pwm_done),
        .pwm_enable      (pwm_enable),
        .pwm_ratio       (pwm_ratio),
        .pwm_direction   (pwm_direction),
        .pwm_update      (pwm_update)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] instr;
        logic [7:0] data;
        logic       nack;
    } i2c_exp_t;

    typedef struct {
        logic       en;
        logic [7:0] ratio;
        logic       dir;
        logic       done;
        bit         chk_drive;
    } pwm_exp_t;

    i2c_exp_t i2c_q[$];
    pwm_exp_t pwm_q[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int resp_budget  = 1000000;
    logic [7:0] enc_hi = 8'h00;
    logic [7:0] enc_lo = 8'h00;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_i2c(input logic [1:0] instr, input logic [7:0] data, input logic nack);
        i2c_exp_t e;
        e.instr = instr; e.data = data; e.nack = nack;
        i2c_q.push_back(e);
    endtask

    task automatic push_read_pass();
        push_i2c(I2C_START, 8'h00, 1'b0);
        push_i2c(I2C_WRITE, 8'h6C, 1'b0);
        push_i2c(I2C_WRITE, 8'h0C, 1'b0);
        push_i2c(I2C_START, 8'h00, 1'b0);
        push_i2c(I2C_WRITE, 8'h6D, 1'b0);
        push_i2c(I2C_READ,  8'h00, 1'b0);
        push_i2c(I2C_READ,  8'h00, 1'b1);
        push_i2c(I2C_STOP,  8'h00, 1'b0);
    endtask

    task automatic push_pwm(input logic en, input logic [7:0] ratio, input logic dir,
                            input logic done, input bit chk_drive);
        pwm_exp_t p;
        p.en = en; p.ratio = ratio; p.dir = dir; p.done = done; p.chk_drive = chk_drive;
        pwm_q.push_back(p);
    endtask

    task automatic pulse_update(input logic [11:0] tgt);
        target_angle = tgt;
        angle_update = 1'b1;
        @(negedge clock);
        angle_update = 1'b0;
    endtask

    task automatic pulse_pwm_done();
        pwm_done = 1'b1;
        @(negedge clock);
        pwm_done = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n = 0;
        while ((i2c_q.size() != 0 || pwm_q.size() != 0) && n < max_cyc) begin
            @(negedge clock); #1;
            n++;
        end
        check_eq({name, "_drained"}, int'(i2c_q.size() + pwm_q.size()), 0);
        i2c_q.delete();
        pwm_q.delete();
    endtask

    // I2C slave model: answers each request two cycles later with one done pulse.
    initial begin : i2c_responder
        logic [1:0] instr;
        int rd_idx = 0;
        i2c_done    = 1'b0;
        i2c_rd_data = 8'h00;
        forever begin
            @(negedge clock);
            while (i2c_req && reset_n && resp_budget > 0) begin
                resp_budget--;
                instr = i2c_instruction;
                repeat (2) @(negedge clock);
                if (instr == I2C_START) rd_idx = 0;
                if (instr == I2C_READ) begin
                    i2c_rd_data = (rd_idx == 0) ? enc_hi : enc_lo;
                    rd_idx++;
                end
                i2c_done = 1'b1;
                @(negedge clock);
                i2c_done = 1'b0;
            end
        end
    end

    // Monitor: compares every presented I2C request and PWM update with the queues.
    initial begin : monitor
        i2c_exp_t ie;
        pwm_exp_t pe;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (i2c_req) begin
                    check_eq("i2c_req_expected", int'(i2c_q.size() != 0), 1);
                    if (i2c_q.size() != 0) begin
                        ie = i2c_q.pop_front();
                        check_eq("i2c_instruction", int'(i2c_instruction), int'(ie.instr));
                        if (ie.instr == I2C_WRITE)
                            check_eq("i2c_wr_data", int'(i2c_wr_data), int'(ie.data));
                        if (ie.instr == I2C_READ)
                            check_eq("i2c_send_nack", int'(i2c_send_nack), int'(ie.nack));
                    end
                end
                if (pwm_update) begin
                    check_eq("pwm_update_expected", int'(pwm_q.size() != 0), 1);
                    if (pwm_q.size() != 0) begin
                        pe = pwm_q.pop_front();
                        check_eq("pwm_enable", int'(pwm_enable), int'(pe.en));
                        check_eq("angle_done_with_update", int'(angle_done), int'(pe.done));
                        if (pe.chk_drive) begin
                            check_eq("pwm_ratio", int'(pwm_ratio), int'(pe.ratio));
                            check_eq("pwm_direction", int'(pwm_direction), int'(pe.dir));
                        end
                    end
                end else if (angle_done) begin
                    check_eq("angle_done_without_update", 1, 0);
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        check_eq({name, "_busy"},       int'(busy), 0);
        check_eq({name, "_angle_done"}, int'(angle_done), 0);
        check_eq({name, "_error"},      int'(error), 0);
        check_eq({name, "_i2c_req"},    int'(i2c_req), 0);
        check_eq({name, "_i2c_instr"},  int'(i2c_instruction), 0);
        check_eq({name, "_i2c_wr"},     int'(i2c_wr_data), 0);
        check_eq({name, "_i2c_nack"},   int'(i2c_send_nack), 0);
        check_eq({name, "_pwm_en"},     int'(pwm_enable), 0);
        check_eq({name, "_pwm_ratio"},  int'(pwm_ratio), 0);
        check_eq({name, "_pwm_dir"},    int'(pwm_direction), 0);
        check_eq({name, "_pwm_upd"},    int'(pwm_update), 0);
    endtask

    initial begin : stimulus
        int t0;
        int n;
        reset_n      = 1'b0;
        target_angle = '0;
        angle_update = 1'b0;
        pwm_done     = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // A: on target at once (target 100, encoder 100)
        enc_hi = 8'h00; enc_lo = 8'h64;
        push_read_pass();
        push_pwm(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        pulse_update(12'd100);
        check_eq("a_req_next_cycle", int'(i2c_req), 1);
        check_eq("a_busy", int'(busy), 1);
        wait_drain("a", 200);
        repeat (20) @(negedge clock);
        check_eq("a_busy_after_done", int'(busy), 0);

        // B: wrap-around error 196 -> ratio 49, then a second pass lands on target
        enc_hi = 8'h0F; enc_lo = 8'hA0;
        push_read_pass();
        push_pwm(1'b1, 8'd49, 1'b1, 1'b0, 1'b1);
        pulse_update(12'd100);
        wait_drain("b1", 200);
        check_eq("b_busy_in_pwm_wait", int'(busy), 1);
        enc_hi = 8'h00; enc_lo = 8'h64;
        push_read_pass();
        push_pwm(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        pulse_pwm_done();
        wait_drain("b2", 200);

        // C: small error 10 -> ratio floored at 20
        push_read_pass();
        push_pwm(1'b1, 8'd20, 1'b1, 1'b0, 1'b1);
        pulse_update(12'd110);
        wait_drain("c1", 200);
        push_read_pass();
        push_pwm(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        pulse_update(12'd100);
        pulse_pwm_done();
        wait_drain("c2", 200);

        // D: half-turn error -> dir 0, ratio saturates at 255
        enc_hi = 8'h08; enc_lo = 8'h00;
        push_read_pass();
        push_pwm(1'b1, 8'd255, 1'b0, 1'b0, 1'b1);
        pulse_update(12'd0);
        wait_drain("d1", 200);
        push_read_pass();
        push_pwm(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        pulse_update(12'd2048);
        pulse_pwm_done();
        wait_drain("d2", 200);
        check_eq("d_ratio_held", int'(pwm_ratio), 255);

        // E: reset while the high byte read is outstanding
        resp_budget = 5;
        push_i2c(I2C_START, 8'h00, 1'b0);
        push_i2c(I2C_WRITE, 8'h6C, 1'b0);
        push_i2c(I2C_WRITE, 8'h0C, 1'b0);
        push_i2c(I2C_START, 8'h00, 1'b0);
        push_i2c(I2C_WRITE, 8'h6D, 1'b0);
        push_i2c(I2C_READ,  8'h00, 1'b0);
        pulse_update(12'd500);
        wait_drain("e_to_rd_hi", 200);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(negedge clock);
        reset_n     = 1'b1;
        resp_budget = 1000000;
        repeat (2) @(negedge clock);
        enc_hi = 8'h01; enc_lo = 8'hF4;
        push_read_pass();
        push_pwm(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        pulse_update(12'd500);
        wait_drain("e_clean", 200);

`ifdef STEER_TIMEOUT_EN
        // F: watchdog fires TIMEOUT_CYC cycles after an unanswered request
        resp_budget = 0;
        push_i2c(I2C_START, 8'h00, 1'b0);
        push_pwm(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        pulse_update(12'd300);
        t0 = cyc;
        n  = 0;
        while (!error && n < 300) begin
            @(negedge clock);
            n++;
        end
        check_eq("f_error_latency", cyc - t0, 100);
        check_eq("f_error", int'(error), 1);
        check_eq("f_busy", int'(busy), 0);
        check_eq("f_pwm_en", int'(pwm_enable), 0);
        wait_drain("f_err", 10);
        resp_budget = 1000000;
        enc_hi = 8'h01; enc_lo = 8'h2C;
        push_read_pass();
        push_pwm(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        pulse_update(12'd300);
        check_eq("f_error_cleared", int'(error), 0);
        wait_drain("f_restart", 200);
`else
        t0 = 0;
        n  = 0;
`endif

        repeat (10) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
